// File: rtl/keypad_pkg.sv
// Shared types and default timing constants for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int unsigned SETTLE_CYCLES_DEF   = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

endpackage : keypad_pkg

// File: rtl/keypad_scan_debounce_if.sv
// Keypad matrix pins plus the decoded key event outputs.
interface keypad_scan_debounce_if #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
);
    localparam int unsigned CODE_W = $clog2(ROWS * COLS);

    logic [COLS-1:0]   col_n;
    logic [ROWS-1:0]   row_n;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_held;

    modport master (
        output col_n,
        input  row_n,
        input  key_valid,
        input  key_code,
        input  key_held
    );

    modport slave (
        input  col_n,
        output row_n,
        output key_valid,
        output key_code,
        output key_held
    );

endinterface : keypad_scan_debounce_if

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/keypad_scan_debounce.sv
// Row-scanning keypad decoder: one key is latched, debounced on press and
// release, and reported as a single key_valid pulse with its code.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SETTLE_CYCLES   = SETTLE_CYCLES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    keypad_scan_debounce_if.slave kif
);

    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned CODE_W  = $clog2(ROWS * COLS);
    localparam int unsigned DWELL_W = $clog2(SETTLE_CYCLES);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(SETTLE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_DONE   = DEB_W'(DEBOUNCE_CYCLES);

    logic [COLS-1:0] col_s;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row_idx, row_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
    logic [DEB_W-1:0]   deb_cnt, deb_nxt;
    logic [DEB_W-1:0]   deb_inc;
    logic [COL_W-1:0]   lat_col, lat_col_nxt;
    logic [COL_W-1:0]   low_col;
    logic               lat_high;
    logic [ROW_W-1:0]   row_adv;

    logic [ROWS-1:0]    row_q;
    logic               valid_q, valid_nxt;
    logic [CODE_W-1:0]  code_q, code_nxt;
    logic               held_q, held_nxt;

    sync_2ff #(
        .WIDTH (COLS)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (kif.col_n),
        .q     (col_s)
    );

    // Lowest-index active column wins when several are pressed together.
    always_comb begin
        low_col = '0;
        for (int i = int'(COLS) - 1; i >= 0; i--) begin
            if (!col_s[i]) low_col = COL_W'(i);
        end
    end

    assign lat_high = col_s[lat_col];
    assign deb_inc  = deb_cnt + 1'b1;
    assign row_adv  = (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;

    always_comb begin
        state_nxt   = state;
        row_nxt     = row_idx;
        dwell_nxt   = dwell_cnt;
        deb_nxt     = deb_cnt;
        lat_col_nxt = lat_col;
        valid_nxt   = 1'b0;
        code_nxt    = code_q;
        held_nxt    = held_q;

        case (state)
            SCAN: begin
                held_nxt = 1'b0;
                if (dwell_cnt == LAST_DWELL) begin
                    dwell_nxt = '0;
                    if (&col_s) begin
                        row_nxt = row_adv;
                    end else begin
                        lat_col_nxt = low_col;
                        deb_nxt     = '0;
                        state_nxt   = DEBOUNCE;
                    end
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (lat_high) begin
                    deb_nxt   = '0;
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else if (deb_inc == DEB_DONE) begin
                    deb_nxt   = '0;
                    valid_nxt = 1'b1;
                    held_nxt  = 1'b1;
                    code_nxt  = CODE_W'(32'(row_idx) * COLS + 32'(lat_col));
                    state_nxt = HELD;
                end else begin
                    deb_nxt = deb_inc;
                end
            end

            HELD: begin
                held_nxt = 1'b1;
                if (lat_high) begin
                    deb_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                if (!lat_high) begin
                    deb_nxt   = '0;
                    state_nxt = HELD;
                end else if (deb_inc == DEB_DONE) begin
                    deb_nxt   = '0;
                    held_nxt  = 1'b0;
                    dwell_nxt = '0;
                    row_nxt   = row_adv;
                    state_nxt = SCAN;
                end else begin
                    deb_nxt = deb_inc;
                end
            end

            default: state_nxt = SCAN;
        endcase
    end

    // Row drive is re-derived from the next row index so it stays one-hot low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= '0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            lat_col   <= '0;
            row_q     <= ~ROWS'(1);
            valid_q   <= 1'b0;
            code_q    <= '0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_nxt;
            dwell_cnt <= dwell_nxt;
            deb_cnt   <= deb_nxt;
            lat_col   <= lat_col_nxt;
            row_q     <= ~(ROWS'(1) << row_nxt);
            valid_q   <= valid_nxt;
            code_q    <= code_nxt;
            held_q    <= held_nxt;
        end
    end

    assign kif.row_n     = row_q;
    assign kif.key_valid = valid_q;
    assign kif.key_code  = code_q;
    assign kif.key_held  = held_q;

endmodule : keypad_scan_debounce

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a switch-matrix model closes columns onto
// driven rows; expected key codes are queued and matched against key_valid.
module tb_keypad_scan_debounce;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [ROWS*COLS-1:0] keys = '0;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int         long_pulses = 0;
    logic       kv_prev = 1'b0;

    keypad_scan_debounce_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

    keypad_scan_debounce #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        kif.col_n = '1;
        for (int c = 0; c < int'(COLS); c++) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                if (keys[r*COLS+c] && !kif.row_n[r]) kif.col_n[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (kif.key_valid && !kv_prev) obs_q.push_back(kif.key_code);
        if (kif.key_valid && kv_prev) long_pulses++;
        kv_prev = kif.key_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        keys  = '0;
        cycles(3);
        checks++;
        if (kif.row_n !== 4'b1110) begin errors++; $display("FAIL reset_row_n: got %b expected 1110", kif.row_n); end
        checks++;
        if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", kif.key_valid); end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", kif.key_held); end
        checks++;
        if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %0d expected 0", kif.key_code); end
    endtask

    task automatic test_scan();
        logic [3:0] one;
        logic [3:0] want;
        reset = 1'b1;
        for (int r = 0; r < 5; r++) begin
            one  = 4'b0001;
            want = ~(one << (r % 4));
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (kif.row_n !== want) begin
                    errors++;
                    $display("FAIL scan_row_n: row %0d dwell %0d got %b expected %b", r, k, kif.row_n, want);
                end
                checks++;
                if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL scan_key_valid: got %b expected 0", kif.key_valid); end
                cycles(1);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL scan_no_keys: got %0d key events expected 0", obs_q.size()); end
    endtask

    task automatic test_clean_press();
        int n;
        logic [3:0] got, want;
        keys = '0;
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (obs_q.size() == 0) begin
            errors++; $display("FAIL clean_valid: no key_valid in 200 cycles, expected code 9");
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL clean_code: got %0d expected %0d", got, want); end
        end
        checks++;
        if (kif.row_n !== 4'b1011) begin errors++; $display("FAIL clean_row_frozen: got %b expected 1011", kif.row_n); end
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            checks++;
            if (kif.key_held !== 1'b1) begin errors++; $display("FAIL clean_held: cycle %0d got %b expected 1", i, kif.key_held); end
        end
        keys = '0;
        for (int i = 1; i <= 16; i++) begin
            cycles(1);
            checks++;
            if (kif.key_held !== 1'b1) begin errors++; $display("FAIL clean_held_after_release: cycle %0d got %b expected 1", i, kif.key_held); end
        end
        n = 0;
        while (kif.key_held !== 1'b0 && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL clean_release: key_held got %b expected 0", kif.key_held); end
        checks++;
        if (kif.row_n !== 4'b0111) begin errors++; $display("FAIL clean_next_row: got %b expected 0111", kif.row_n); end
        checks++;
        if (obs_q.size() != 0 || long_pulses != 0) begin
            errors++; $display("FAIL clean_single_pulse: extra events %0d long pulses %0d expected 0 and 0", obs_q.size(), long_pulses);
        end
    endtask

    task automatic test_bounce();
        int n;
        n = 0;
        while (kif.row_n === 4'b1011 && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (kif.row_n !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (kif.row_n !== 4'b1011) begin errors++; $display("FAIL bounce_find_row2: got %b expected 1011", kif.row_n); end
        keys = '0;
        keys[9] = 1'b1;
        cycles(5);
        keys = '0;
        cycles(3);
        checks++;
        if (kif.row_n !== 4'b1011) begin errors++; $display("FAIL bounce_resume_row: got %b expected 1011", kif.row_n); end
        n = 0;
        while (kif.row_n === 4'b1011 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n != 4) begin errors++; $display("FAIL bounce_dwell_restart: got %0d cycles expected 4", n); end
        checks++;
        if (kif.row_n !== 4'b0111) begin errors++; $display("FAIL bounce_next_row: got %b expected 0111", kif.row_n); end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL bounce_no_valid: got %0d events expected 0", obs_q.size()); end
    endtask

    task automatic test_two_keys();
        int n;
        logic [3:0] got, want;
        keys = '0;
        keys[9]  = 1'b1;
        keys[11] = 1'b1;
        exp_q.push_back(4'd9);
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (obs_q.size() == 0) begin
            errors++; $display("FAIL two_first_valid: no key_valid in 200 cycles, expected code 9");
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL two_first_code: got %0d expected %0d", got, want); end
        end
        cycles(10);
        checks++;
        if (obs_q.size() != 0 || kif.key_held !== 1'b1) begin
            errors++; $display("FAIL two_col3_ignored: events %0d held %b expected 0 and 1", obs_q.size(), kif.key_held);
        end
        keys[9] = 1'b0;
        exp_q.push_back(4'd11);
        n = 0;
        while (kif.key_held !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (kif.key_held !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL two_release_first: held %b events %0d expected 0 and 0", kif.key_held, obs_q.size());
        end
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (obs_q.size() == 0) begin
            errors++; $display("FAIL two_second_valid: no key_valid in 200 cycles, expected code 11");
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL two_second_code: got %0d expected %0d", got, want); end
        end
        keys = '0;
        n = 0;
        while (kif.key_held !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL two_final_release: got %b expected 0", kif.key_held); end
    endtask

    task automatic test_glitch();
        int n;
        logic [3:0] got, want;
        keys = '0;
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (obs_q.size() == 0) begin
            errors++; $display("FAIL glitch_first_valid: no key_valid in 200 cycles, expected code 9");
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL glitch_first_code: got %0d expected %0d", got, want); end
        end
        cycles(5);
        keys[9] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            checks++;
            if (kif.key_held !== 1'b1) begin errors++; $display("FAIL glitch_held: cycle %0d got %b expected 1", i, kif.key_held); end
        end
        keys[9] = 1'b1;
        cycles(20);
        checks++;
        if (kif.key_held !== 1'b1 || obs_q.size() != 0) begin
            errors++; $display("FAIL glitch_no_repeat: held %b events %0d expected 1 and 0", kif.key_held, obs_q.size());
        end
        keys = '0;
        n = 0;
        while (kif.key_held !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL glitch_release: got %b expected 0", kif.key_held); end
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (obs_q.size() == 0) begin
            errors++; $display("FAIL glitch_repress_valid: no key_valid in 200 cycles, expected code 9");
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin errors++; $display("FAIL glitch_repress_code: got %0d expected %0d", got, want); end
        end
        keys = '0;
        n = 0;
        while (kif.key_held !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (kif.key_held !== 1'b0) begin errors++; $display("FAIL glitch_final_release: got %b expected 0", kif.key_held); end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (kif.row_n === 4'b1101 && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (kif.row_n !== 4'b1101 && n < 40) begin @(negedge clk); n++; end
        keys = '0;
        keys[4] = 1'b1;
        cycles(14);
        checks++;
        if (kif.row_n !== 4'b1101 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL midreset_setup: row_n %b held %b expected 1101 and 0", kif.row_n, kif.key_held);
        end
        reset = 1'b0;
        keys  = '0;
        #1;
        checks++;
        if (kif.row_n !== 4'b1110) begin errors++; $display("FAIL midreset_row_n: got %b expected 1110", kif.row_n); end
        checks++;
        if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: valid %b held %b expected 0 and 0", kif.key_valid, kif.key_held);
        end
        checks++;
        if (kif.key_code !== 4'd0) begin errors++; $display("FAIL midreset_code: got %0d expected 0", kif.key_code); end
        cycles(2);
        reset = 1'b1;
        cycles(3);
        checks++;
        if (kif.row_n !== 4'b1110) begin errors++; $display("FAIL midreset_restart_row0: got %b expected 1110", kif.row_n); end
        cycles(1);
        checks++;
        if (kif.row_n !== 4'b1101) begin errors++; $display("FAIL midreset_restart_row1: got %b expected 1101", kif.row_n); end
        cycles(30);
        checks++;
        if (obs_q.size() != 0 || long_pulses != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL midreset_no_valid: events %0d long %0d pending %0d expected 0 0 0", obs_q.size(), long_pulses, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_keypad_scan_debounce

// File: doc/keypad_scan_debounce.md
KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 Parameter ROWS, default 4: number of keypad rows driven; SHALL be >= 2.
REQ-002 Parameter COLS, default 4: number of keypad columns sensed; SHALL be >= 2.
REQ-003 Parameter SETTLE_CYCLES, default 4: clk cycles each row is driven while scanning; SHALL be >= 3.
REQ-004 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required for press or release; SHALL be >= 2.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 col_n  input  COLS  raw active-low column sense lines, asynchronous to clk.
REQ-008 row_n  output  ROWS  registered active-low row drive; exactly one bit low at all times.
REQ-009 key_valid  output  1  one-cycle pulse on debounced press.
REQ-010 key_code  output  clog2(ROWS*COLS)  row_index*COLS + col_index of the accepted key.
REQ-011 key_held  output  1  high from key_valid through release confirmation.

Function
REQ-012 col_n SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (col_s).
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: current row driven low for SETTLE_CYCLES; on the last dwell cycle, if col_s is all ones, the row index SHALL advance (ROWS-1 wraps to 0) with dwell counter cleared.
REQ-015 SCAN: on the last dwell cycle with any col_s bit low, the block SHALL latch the row index and the lowest-index low column, freeze row_n, and enter DEBOUNCE.
REQ-016 DEBOUNCE: a counter SHALL increment each cycle the latched column is low; if it reads high, counter clears and the FSM returns to SCAN on the same row with dwell restarted.
REQ-017 DEBOUNCE: on the cycle the count reaches DEBOUNCE_CYCLES, key_valid SHALL pulse for exactly one cycle, key_code SHALL update in the same cycle, and the FSM SHALL enter HELD.
REQ-018 HELD: key_held=1; row_n frozen; when the latched column reads high, the FSM SHALL enter RELEASE with counter cleared.
REQ-019 RELEASE: counter increments while the latched column is high; a low reading SHALL return to HELD with no new key_valid.
REQ-020 RELEASE: on reaching DEBOUNCE_CYCLES, key_held SHALL drop and the FSM SHALL enter SCAN at the next row (wrapping).
REQ-021 Additional keys pressed while in DEBOUNCE/HELD/RELEASE SHALL be ignored; key_code SHALL hold its value until the next key_valid.
REQ-022 Counters SHALL be sized to clog2 of their maximum value +1 and SHALL never wrap.

Reset
REQ-023 During reset: state=SCAN, row index 0, row_n = all ones except bit 0 low, key_valid=0, key_held=0, key_code=0, counters and synchronizer flops cleared.
REQ-024 Reset asserted mid-operation SHALL abort any press in progress without emitting key_valid; scanning SHALL restart at row 0 on the first clk edge after deassertion.

Structure
REQ-025 The state enum typedef and the SETTLE/DEBOUNCE default constants SHALL live in a shared package keypad_pkg.
REQ-026 The synchronizer SHALL be a sub-module sync_2ff, parametrised by WIDTH, with its own async active-low reset.

Verification (ROWS=4, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_CYCLES=16)
REQ-027 No key pressed -> row_n sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles; key_valid never high.
REQ-028 Clean hold of row 2/col 1 (col_n=1101 while row_n=1011) -> exactly one key_valid, key_code=9, key_held high until 16 cycles after release.
REQ-029 Row 2/col 1 bouncing low for 5 cycles then high -> no key_valid; scan resumes on row 2.
REQ-030 Row 2 cols 1 and 3 both low -> key_code=9; col 3 ignored until release completes.
REQ-031 During HELD, column glitches high for 8 cycles -> no second key_valid; full release then re-press -> second key_valid, key_code=9.
REQ-032 reset pulsed at DEBOUNCE count 10 -> row_n=1110, key_valid=0, key_held=0 immediately; scanning restarts at row 0.
